nrf24_spi_responder: RTL and testbench
======================================

// Module: nrf24_spi_responder
// PURPOSE
//  SPI slave (mode 0, MSB first) emulating the nRF24L01 command/register interface on the
//  DE10-Lite fabric. Lets our SPI master be exercised on hardware/loopback without a radio:
//  returns STATUS on every command byte, serves R_REGISTER/W_REGISTER/NOP, raises IRQ.
//  Sits between the board SPI pins (csn/sck/mosi/miso) and local stimulus logic.
// PARAMETERS
//  SYNC_STAGES  2     flops in csn/sck/mosi synchronisers (>=2)
//  CONFIG_RST   8'h08 reset value of register 0x00 (CONFIG)
//  STATUS_RST   8'h0E reset value of register 0x07 (STATUS)
// PORTS
//  clk        in   1  system clock; sck must be <= clk/4 (10 MHz sck, 50 MHz clk)
//  reset      in   1  asynchronous, active-high
//  csn        in   1  SPI chip select, active-low (async to clk)
//  sck        in   1  SPI clock (async to clk)
//  mosi       in   1  SPI data in
//  miso       out  1  SPI data out; 0 when miso_oe=0
//  miso_oe    out  1  1 while transaction selected (tristate enable at top level)
//  irq_set    in   3  one-cycle set pulses for STATUS[6:4] = {RX_DR,TX_DS,MAX_RT}
//  irq_n      out  1  ~|STATUS[6:4], active-low interrupt
//  cmd_valid  out  1  one-cycle pulse: command byte received
//  cmd_byte   out  8  last command byte; held until next cmd_valid
//  wr_valid   out  1  one-cycle pulse: register written by SPI
//  wr_addr    out  5  address of last write
//  wr_data    out  8  value actually stored by last write
// BEHAVIOUR
//  Reset: all 32 x 8-bit regs 0x00 except reg0=CONFIG_RST, reg7=STATUS_RST; state IDLE;
//   miso=0, miso_oe=0, irq_n=1, cmd_valid=0, wr_valid=0, cmd_byte=0, wr_addr=0, wr_data=0.
//  Inputs pass SYNC_STAGES flops; edges detected on synchronised sck/csn. Pin-to-effect
//   latency SYNC_STAGES+1 clk; miso valid <= SYNC_STAGES+2 clk after sck fall at pin.
//  FSM IDLE -> CMD on csn fall: miso_oe=1, shift-out loaded with STATUS, miso=STATUS[7].
//  Bit counter (3 bit) wraps 7->0 each byte. mosi sampled on sck rise; next out-bit on sck fall.
//  CMD, 8th rise: cmd_byte<=byte, cmd_valid pulse, go DATA. Decode:
//   000aaaaa R_REGISTER: shift-out reloaded with reg[a] for each following byte.
//   001aaaaa W_REGISTER: each following complete byte writes reg[a] (same addr, no increment).
//   0xFF NOP and all other opcodes: following bytes return 0x00, no writes.
//  Address range 0x1E-0x1F: reads 0x00, writes ignored (no wr_valid).
//  Write rules: reg7 bits 6:4 write-1-to-clear, bits 3:0 and 7 read-only;
//   all other regs fully writable. wr_data = post-write stored value.
//  STATUS read value is captured at csn fall (CMD) / at byte boundary (DATA).
//  irq_set bit and W1C of same bit in same clk: set wins (bit stays 1).
//  csn rise in any state: -> IDLE next clk, miso_oe=0, miso=0, partial byte discarded
//   (no cmd_valid/wr_valid); cmd_byte/wr_* hold.
//  csn fall while already selected cannot occur; sck edges while csn high ignored.
//  reset mid-transaction: immediate return to reset values; next transaction needs csn fall.
// TESTING
//  1 reset; NOP 0xFF -> miso byte 0x0E; cmd_valid 1 clk, cmd_byte=0xFF; no wr_valid.
//  2 bytes 0x20,0x0B then 0x00,0xFF -> wr_valid addr 0 data 0x0B; 2nd txn returns 0x0E,0x0B.
//  3 irq_set=3'b010 -> irq_n=0; R_REG 0x07 -> 0x2E; W 0x27,0x20 -> STATUS 0x0E, irq_n=1.
//  4 send 0x21 + 4 bits of data, csn high -> no wr_valid, reg1 unchanged, miso_oe=0.
//  5 reset asserted mid data byte -> miso_oe=0 same cycle, reg0 reads 0x08 afterwards.
//  6 irq_set[2] pulse on same clk as W1C 0x40 to STATUS -> STATUS[6]=1, irq_n=0.

Source files
------------

// File: rtl/nrf24_spi_responder.sv
// nRF24L01 command/register interface emulated as an SPI mode-0 slave.
// It serves STATUS, R_REGISTER, W_REGISTER and NOP, and drives an active-low IRQ from STATUS[6:4].
module nrf24_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CONFIG_RST  = 8'h08,
  parameter logic [7:0]  STATUS_RST  = 8'h0E
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       csn,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [2:0] irq_set,
  output logic       irq_n,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       wr_valid,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_NONE} op_t;

  localparam logic [4:0] STATUS_ADDR = 5'h07;
  localparam logic [4:0] LAST_ADDR   = 5'h1D;

  function automatic op_t decode_op(input logic [2:0] opcode);
    case (opcode)
      3'b000:  return OP_READ;
      3'b001:  return OP_WRITE;
      default: return OP_NONE;
    endcase
  endfunction

  state_t state_q, state_d;
  op_t    op_q, cmd_op, cur_op;

  logic [SYNC_STAGES-1:0] csn_sync, sck_sync, mosi_sync;
  logic       csn_s, sck_s, mosi_s, csn_d, sck_d;
  logic       csn_fall, sck_rise, sck_fall, byte_done, do_write, addr_ok;
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] shift_out, rx_byte, rd_value, wr_value, status_set;
  logic [4:0] addr_q, cur_addr;
  logic [7:0] regs [32];

  // csn resets low so a csn already low when reset releases does not look like a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csn_sync  <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      csn_d     <= 1'b0;
      sck_d     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking ones would collapse the chain.
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      csn_d     <= csn_s;
      sck_d     <= sck_s;
    end
  end

  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign csn_fall = csn_d & ~csn_s;
  assign sck_rise = sck_s & ~sck_d & ~csn_s;
  assign sck_fall = ~sck_s & sck_d & ~csn_s;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rx_byte    = {shift_in, mosi_s};
    cmd_op     = decode_op(rx_byte[7:5]);
    cur_op     = (state_q == CMD) ? cmd_op : op_q;
    cur_addr   = (state_q == CMD) ? rx_byte[4:0] : addr_q;
    addr_ok    = (cur_addr <= LAST_ADDR);
    rd_value   = (cur_op == OP_READ && addr_ok) ? regs[cur_addr] : 8'h00;
    status_set = regs[STATUS_ADDR] | {1'b0, irq_set, 4'b0000};
    // STATUS: bit 7 and 3:0 read-only, 6:4 write-1-to-clear, a simultaneous set wins.
    wr_value   = (cur_addr == STATUS_ADDR)
               ? {regs[STATUS_ADDR][7],
                  (regs[STATUS_ADDR][6:4] & ~rx_byte[6:4]) | irq_set,
                  regs[STATUS_ADDR][3:0]}
               : rx_byte;
    byte_done  = (state_q != IDLE) && sck_rise && (bit_cnt == 3'd7);
    do_write   = byte_done && (state_q == DATA) && (op_q == OP_WRITE) && addr_ok;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (csn_fall) state_d = CMD;
      CMD:     if (csn_s) state_d = IDLE;
               else if (byte_done) state_d = DATA;
      DATA:    if (csn_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the register file must come up in a defined state, so it sits on the reset like any other flop.
      for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
      regs[0]           <= CONFIG_RST;
      regs[STATUS_ADDR] <= STATUS_RST;
      op_q      <= OP_NONE;
      addr_q    <= '0;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      miso      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte  <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      cmd_valid         <= 1'b0;
      wr_valid          <= 1'b0;
      regs[STATUS_ADDR] <= status_set;
      if (state_q == IDLE) begin
        if (csn_fall) begin
          shift_out <= regs[STATUS_ADDR];
          miso      <= regs[STATUS_ADDR][7];
          bit_cnt   <= '0;
        end
      end else if (csn_s) begin
        miso    <= 1'b0;
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shift_in <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (byte_done) begin
          shift_out <= rd_value;
          if (state_q == CMD) begin
            cmd_byte  <= rx_byte;
            cmd_valid <= 1'b1;
            op_q      <= cmd_op;
            addr_q    <= rx_byte[4:0];
          end
          if (do_write) begin
            regs[addr_q] <= wr_value;
            wr_valid     <= 1'b1;
            wr_addr      <= addr_q;
            wr_data      <= wr_value;
          end
        end
      end else if (sck_fall) begin
        miso <= shift_out[3'd7 - bit_cnt];
      end
    end
  end

  assign miso_oe = (state_q != IDLE);
  assign irq_n   = ~|regs[STATUS_ADDR][6:4];

endmodule

// File: tb/tb_nrf24_spi_responder.sv
// Scoreboard bench for nrf24_spi_responder: a transaction-level register model predicts
// miso bytes, command and write pulses; a monitor pops and compares as the DUT produces them.
module tb_nrf24_spi_responder;
  localparam int SYNC  = 2;
  localparam int CLK_P = 20;
  localparam int HALF  = 5 * CLK_P;

  logic       clk = 1'b0, reset = 1'b1, csn = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic [2:0] irq_set = 3'b000;
  logic       miso, miso_oe, irq_n, cmd_valid, wr_valid;
  logic [7:0] cmd_byte, wr_data;
  logic [4:0] wr_addr;

  always #(CLK_P / 2) clk = ~clk;

  nrf24_spi_responder #(.SYNC_STAGES(SYNC), .CONFIG_RST(8'h08), .STATUS_RST(8'h0E)) dut (
    .clk(clk), .reset(reset), .csn(csn), .sck(sck), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .irq_set(irq_set), .irq_n(irq_n), .cmd_valid(cmd_valid),
    .cmd_byte(cmd_byte), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int          n_checks = 0, n_pass = 0;
  logic [7:0]  mregs [32];
  logic [7:0]  exp_cmd_q[$], exp_miso_q[$], got_miso_q[$];
  logic [12:0] exp_wr_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic flag_unexpected(input string name);
    n_checks++;
    $display("FAIL %s: output seen, none expected at %0t", name, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 8'h00;
    mregs[0] = 8'h08;
    mregs[7] = 8'h0E;
  endtask

  // Bytes are packed MSB-first in pk; n of them are sent as one transaction.
  task automatic model_txn(input logic [31:0] pk, input int n, input logic [2:0] last_irq);
    logic [7:0] c, d;
    logic [4:0] a;
    bit rd, wr, in_range;
    c = pk[31:24];
    a = c[4:0];
    rd = (c[7:5] == 3'b000);
    wr = (c[7:5] == 3'b001);
    in_range = (a < 5'd30);
    exp_miso_q.push_back(mregs[7]);
    exp_cmd_q.push_back(c);
    for (int i = 1; i < n; i++) begin
      d = pk[31 - 8 * i -: 8];
      exp_miso_q.push_back((rd && in_range) ? mregs[a] : 8'h00);
      if (wr && in_range) begin
        if (a == 5'd7) mregs[7] = mregs[7] & ~(d & 8'h70);
        else           mregs[a] = d;
      end
      if (i == n - 1) mregs[7] = mregs[7] | {1'b0, last_irq, 4'b0000};
      if (wr && in_range) exp_wr_q.push_back({a, mregs[a]});
    end
  endtask

  task automatic xfer_byte(input logic [7:0] tx, input logic [2:0] irq_on_last, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #HALF;
      rx[i] = miso;
      sck = 1'b1;
      if (i == 0 && irq_on_last != 3'b000) begin
        // Lands on the clock where the DUT commits this byte.
        #(CLK_P * SYNC);
        irq_set = irq_on_last;
        #CLK_P;
        irq_set = 3'b000;
        #(HALF - CLK_P * (SYNC + 1));
      end else begin
        #HALF;
      end
      sck = 1'b0;
    end
  endtask

  task automatic run_txn(input logic [31:0] pk, input int n, input int tail_bits, input logic [2:0] last_irq);
    logic [7:0] rx;
    model_txn(pk, n, last_irq);
    csn = 1'b0;
    #(4 * CLK_P);
    for (int i = 0; i < n; i++) begin
      xfer_byte(pk[31 - 8 * i -: 8], (i == n - 1) ? last_irq : 3'b000, rx);
      got_miso_q.push_back(rx);
    end
    for (int b = 0; b < tail_bits; b++) begin
      mosi = 1'($urandom);
      #HALF; sck = 1'b1;
      #HALF; sck = 1'b0;
    end
    #HALF;
    csn = 1'b1;
    #(6 * CLK_P);
    check("miso_oe_after_csn", miso_oe, 1'b0);
    check("miso_after_csn", miso, 1'b0);
    check("irq_n", irq_n, ~|mregs[7][6:4]);
  endtask

  task automatic pulse_irq(input logic [2:0] v);
    irq_set = v;
    mregs[7] = mregs[7] | {1'b0, v, 4'b0000};
    #CLK_P;
    irq_set = 3'b000;
    #CLK_P;
  endtask

  always @(negedge clk) begin
    if (cmd_valid) begin
      if (exp_cmd_q.size() == 0) flag_unexpected("cmd_valid");
      else check("cmd_byte", cmd_byte, exp_cmd_q.pop_front());
    end
    if (wr_valid) begin
      if (exp_wr_q.size() == 0) flag_unexpected("wr_valid");
      else check("wr_addr_data", {wr_addr, wr_data}, exp_wr_q.pop_front());
    end
    if (got_miso_q.size() != 0) begin
      if (exp_miso_q.size() == 0) flag_unexpected("miso_byte");
      else check("miso_byte", got_miso_q.pop_front(), exp_miso_q.pop_front());
    end
  end

  initial begin
    logic [7:0]  rx, c;
    logic [4:0]  a;
    logic [31:0] pk;
    int          kind, n;

    model_reset();
    #(3 * CLK_P + 5);
    check("rst_miso", miso, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_irq_n", irq_n, 1'b1);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_cmd_byte", cmd_byte, 8'h00);
    check("rst_wr_addr", wr_addr, 5'h00);
    check("rst_wr_data", wr_data, 8'h00);
    reset = 1'b0;
    #(4 * CLK_P);

    // NOP returns STATUS then zero; W_REGISTER reg0 then read it back.
    run_txn({8'hFF, 8'h00, 16'h0}, 2, 0, 3'b000);
    run_txn({8'h20, 8'h0B, 16'h0}, 2, 0, 3'b000);
    run_txn({8'h00, 8'hFF, 16'h0}, 2, 0, 3'b000);

    // TX_DS raised, read STATUS, then clear it.
    pulse_irq(3'b010);
    check("irq_n_after_set", irq_n, 1'b0);
    run_txn({8'h07, 8'h00, 16'h0}, 2, 0, 3'b000);
    run_txn({8'h27, 8'h20, 16'h0}, 2, 0, 3'b000);

    // Aborted write: partial data byte must be discarded.
    run_txn({8'h21, 8'h3C, 16'h0}, 2, 0, 3'b000);
    run_txn({8'h21, 24'h0}, 1, 4, 3'b000);
    run_txn({8'h01, 8'h00, 16'h0}, 2, 0, 3'b000);

    // Out-of-range addresses read zero and ignore writes.
    run_txn({8'h3E, 8'h55, 16'h0}, 2, 0, 3'b000);
    run_txn({8'h1E, 8'h00, 8'h1F, 8'h00}, 2, 0, 3'b000);

    // Reset in the middle of a read data byte.
    run_txn({8'h20, 8'h5A, 16'h0}, 2, 0, 3'b000);
    model_txn({8'h00, 24'h0}, 1, 3'b000);
    csn = 1'b0;
    #(4 * CLK_P);
    xfer_byte(8'h00, 3'b000, rx);
    got_miso_q.push_back(rx);
    for (int b = 0; b < 3; b++) begin
      mosi = 1'($urandom);
      #HALF; sck = 1'b1;
      #HALF; sck = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("miso_oe_on_reset", miso_oe, 1'b0);
    check("miso_on_reset", miso, 1'b0);
    check("cmd_byte_on_reset", cmd_byte, 8'h00);
    model_reset();
    #(3 * CLK_P - 1);
    reset = 1'b0;
    for (int b = 0; b < 8; b++) begin
      mosi = 1'($urandom);
      #HALF; sck = 1'b1;
      #HALF; sck = 1'b0;
    end
    check("miso_oe_held_idle", miso_oe, 1'b0);
    csn = 1'b1;
    #(6 * CLK_P);
    run_txn({8'h00, 8'h00, 16'h0}, 2, 0, 3'b000);

    // RX_DR set on the same clock as its write-1-to-clear: set wins.
    run_txn({8'h27, 8'h40, 16'h0}, 2, 0, 3'b100);
    run_txn({8'hFF, 24'h0}, 1, 0, 3'b000);
    run_txn({8'h27, 8'h70, 16'h0}, 2, 0, 3'b000);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) pulse_irq(3'($urandom_range(1, 7)));
      a    = ($urandom_range(0, 3) == 0) ? 5'd7 : 5'($urandom_range(0, 31));
      kind = $urandom_range(0, 9);
      if (kind < 4)       c = {3'b000, a};
      else if (kind < 8)  c = {3'b001, a};
      else if (kind == 8) c = 8'hFF;
      else                c = {3'($urandom_range(2, 7)), 5'($urandom)};
      n  = $urandom_range(1, 4);
      pk = {c, 24'($urandom)};
      run_txn(pk, n, 0, 3'b000);
    end

    #(10 * CLK_P);
    check("exp_cmd_drained", exp_cmd_q.size(), 0);
    check("exp_wr_drained", exp_wr_q.size(), 0);
    check("exp_miso_drained", exp_miso_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
